// File: rtl/ifetch_stage.sv
// ============================================================================
// Module   : ifetch_stage
// Purpose  : PC, ITCM word fetch, one-entry skid buffer and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic [6:0]  id_opcode_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        outstanding_q, outstanding_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;

    logic [2:0]  w_occ;
    logic        w_xfer;
    logic        w_resp;
    logic        w_id_free;

    // Slots that will still be occupied next cycle, counting the in-flight read.
    assign w_occ = {2'b00, id_valid_q} + {2'b00, skid_valid_q} + {2'b00, outstanding_q}
                 - {2'b00, id_valid_q & ~stall_i};

    assign imem_req_o  = (state_q != S_BOOT) && (w_occ < 3'd2);
    assign imem_addr_o = pc_q;
    assign w_xfer      = imem_req_o & imem_gnt_i;
    assign w_resp      = imem_rvalid_i & outstanding_q & (state_q != S_FLUSH) & ~redirect_i;
    assign w_id_free   = ~id_valid_q | ~stall_i;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = w_xfer | (outstanding_q & ~imem_rvalid_i);
        resp_pc_d     = resp_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_inst_d   = skid_inst_q;
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_inst_d     = id_inst_q;

        case (state_q)
            S_BOOT:          state_d = S_RUN;
            S_RUN, S_FLUSH:  state_d = (redirect_i && w_xfer) ? S_FLUSH : S_RUN;
            default:         state_d = S_BOOT;
        endcase

        if (w_xfer) begin
            resp_pc_d = pc_q;
        end

        if (redirect_i) begin
            pc_d         = redirect_pc_i & 32'hFFFF_FFFC;
            id_valid_d   = 1'b0;
            id_inst_d    = NOP_INST;
            skid_valid_d = 1'b0;
        end else begin
            if (w_xfer) begin
                pc_d = pc_q + 32'd4;
            end
            // The skid entry is older than any new response, so it drains first.
            if (w_id_free) begin
                if (skid_valid_q) begin
                    id_valid_d   = 1'b1;
                    id_pc_d      = skid_pc_q;
                    id_inst_d    = skid_inst_q;
                    skid_valid_d = w_resp;
                    if (w_resp) begin
                        skid_pc_d   = resp_pc_q;
                        skid_inst_d = imem_rdata_i;
                    end
                end else if (w_resp) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = resp_pc_q;
                    id_inst_d  = imem_rdata_i;
                end else begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
            end else if (w_resp) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = resp_pc_q;
                skid_inst_d  = imem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= 1'b0;
            resp_pc_q     <= 32'h0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= 32'h0;
            skid_inst_q   <= NOP_INST;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'h0;
            id_inst_q     <= NOP_INST;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            resp_pc_q     <= resp_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_inst_q   <= skid_inst_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
        end
    end

    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_inst_o   = id_inst_q;
    assign id_opcode_o = id_inst_q[6:0];

endmodule

`default_nettype wire
